game_undo_buffer: RTL and testbench
===================================

Name: game_undo_buffer

Overview:
- Upstream stage of the 4-to-1 game-state mux.
- Holds the last four committed Sokoban game states (N-bit packed board plus player data) in a 4-slot ring, so the player can undo up to three moves.
- Drives the four slot buses straight into the mux data inputs, and a 2-bit pointer into the mux select; the mux output is always the current state.
- Also keeps the move counter shown on the scoreboard.

Parameters:
- N, 134, width of one packed game state (must match the mux).
- MOVE_W, 16, width of the move counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load  input  1  one-cycle strobe: start a level from load_state.
- load_state  input  N  initial level state from the level ROM.
- push  input  1  one-cycle strobe: commit push_state as the new current state.
- push_state  input  N  next state computed by the move logic.
- undo  input  1  one-cycle strobe: revert to the previous state.
- slot_0, slot_1, slot_2, slot_3  output  N each  ring contents, wired to mux in_0..in_3.
- sel  output  2  index of the current slot, wired to mux sel.
- depth  output  3  number of valid states held, 0..4.
- valid  output  1  high when depth != 0.
- undo_err  output  1  one-cycle pulse: an undo was rejected.
- moves  output  MOVE_W  net move count.
- undo_total  output  16  total accepted undos (see Optional Feature).

Behaviour:
- All outputs are registered; there is no combinational path from inputs to outputs.
- Async reset (rst_n low) sets:
  - all slots to 0, sel=0, depth=0, valid=0;
  - undo_err=0, moves=0, undo_total=0.
- Command priority per clock edge: load > push > undo.
- load (priority 1):
  - slot[0] <= load_state; other slots are left unchanged but are invalid.
  - sel=0, depth=1, moves=0; undo_total is not cleared.
  - Any push or undo asserted in the same cycle is ignored, with no undo_err.
- push (when no load):
  - If depth==0: slot[sel] <= push_state, depth=1, sel and moves unchanged.
  - Else: slot[sel+1 mod 4] <= push_state, sel <= sel+1 (wraps 3->0), depth <= min(depth+1, 4), moves <= moves+1, saturating at all-ones.
  - With depth==4 the oldest state is overwritten; this is correct, because sel+1 is the oldest slot.
- undo (when no load and no push):
  - If depth>=2: sel <= sel-1 (wraps 0->3), depth <= depth-1, moves <= moves-1 (floor 0), undo_total += 1 (saturating).
  - Slot contents are untouched.
  - If depth<=1: no state change; undo_err pulses high for exactly one cycle.
- undo together with push (no load): the push executes, the undo is dropped, and undo_err pulses.
- Undo limit: at most 3 consecutive undos after 4+ pushes; the 4th undo is rejected.
- A push after an undo discards the redo history: it writes sel+1 and recomputes depth from the post-undo value.
- Latency: a command at edge k appears on slot/sel/depth outputs after edge k. The downstream mux output is valid in the same cycle, one mux delay later.
- valid equals (depth != 0), registered alongside depth.
- Reset mid-operation: immediate return to the reset values; no pending command survives.

Optional Feature:
- Macro: GAME_UNDO_STATS_EN.
- Defined: undo_total is a 16-bit saturating counter of accepted undos. It clears only on reset, not on load; it feeds the scoreboard.
- Undefined: the counter is not built; the undo_total port stays and is tied to 16'd0.

Test Plan:
1. Reset then load(load_state=A) -> sel=0, depth=1, slot_0=A, moves=0, valid=1; undo next cycle -> undo_err one-cycle pulse, sel=0, depth=1.
2. load A, push B, C, D -> sel=3, depth=4, slots {A,B,C,D}, moves=3; push E -> slot_0=E, sel=0 (wrap), depth=4, moves=4.
3. From test 2, undo x3 -> sel steps 3,2,1, depth 3,2,1, moves 3,2,1, mux state D,C,B; 4th undo -> undo_err, no change.
4. load A, push B, undo, push X -> slot_1=X, sel=1, depth=2, moves=1; B is no longer reachable.
5. Simultaneous strobes:
   - load+push+undo in one cycle -> load only: sel=0, depth=1, no undo_err.
   - push+undo in one cycle -> push only, plus undo_err pulse.
6. Assert rst_n low between clock edges during a push sequence -> all outputs zero immediately.
   - With GAME_UNDO_STATS_EN: undo_total counts 3 in test 3, holds 3 after a subsequent load.
   - Without the macro: undo_total stays 0.

Source files
------------

// File: rtl/game_undo_buffer.sv
// game_undo_buffer: four-slot ring of committed Sokoban game states feeding a 4-to-1 state mux.
// The ring holds the current state plus up to three earlier ones, so up to three moves can be undone.
// It also keeps the scoreboard move counter.
// Optional build macro GAME_UNDO_STATS_EN: when defined, undo_total counts accepted undos
// (16-bit, saturating, cleared only by reset). Otherwise undo_total is tied to zero.
module game_undo_buffer #(
   parameter int unsigned N      = 134,
   parameter int unsigned MOVE_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [N-1:0]      load_state,
   input  logic              push,
   input  logic [N-1:0]      push_state,
   input  logic              undo,
   output logic [N-1:0]      slot_0,
   output logic [N-1:0]      slot_1,
   output logic [N-1:0]      slot_2,
   output logic [N-1:0]      slot_3,
   output logic [1:0]        sel,
   output logic [2:0]        depth,
   output logic              valid,
   output logic              undo_err,
   output logic [MOVE_W-1:0] moves,
   output logic [15:0]       undo_total
);

   logic [N-1:0]      slot_q [4];
   logic [1:0]        sel_q, sel_d;
   logic [2:0]        depth_q, depth_d;
   logic              valid_q;
   logic              undo_err_q, undo_err_d;
   logic [MOVE_W-1:0] moves_q, moves_d;

   // Only one slot is written per edge.
   logic              wr_en;
   logic [1:0]        wr_idx;
   logic [N-1:0]      wr_data;

   // Command decode with priority load > push > undo; every output is a register.
   always_comb begin
      wr_en      = 1'b0;
      wr_idx     = sel_q;
      wr_data    = push_state;
      sel_d      = sel_q;
      depth_d    = depth_q;
      moves_d    = moves_q;
      undo_err_d = 1'b0;
      if (load) begin
         // Any push or undo in the same cycle is silently ignored.
         wr_en   = 1'b1;
         wr_idx  = 2'd0;
         wr_data = load_state;
         sel_d   = 2'd0;
         depth_d = 3'd1;
         moves_d = '0;
      end else if (push) begin
         wr_en      = 1'b1;
         undo_err_d = undo;
         if (depth_q == 3'd0) begin
            // Empty ring: the first state lands at the current pointer and is not a move.
            wr_idx  = sel_q;
            depth_d = 3'd1;
         end else begin
            // sel+1 is either free or the oldest state, so overwriting it is always correct.
            // This also drops any redo history left behind by earlier undos.
            wr_idx = sel_q + 2'd1;
            sel_d  = sel_q + 2'd1;
            if (depth_q < 3'd4) begin
               depth_d = depth_q + 3'd1;
            end
            if (moves_q != '1) begin
               moves_d = moves_q + MOVE_W'(1);
            end
         end
      end else if (undo) begin
         if (depth_q >= 3'd2) begin
            sel_d   = sel_q - 2'd1;
            depth_d = depth_q - 3'd1;
            if (moves_q != '0) begin
               moves_d = moves_q - MOVE_W'(1);
            end
         end else begin
            undo_err_d = 1'b1;
         end
      end
   end

   // State registers; reset returns everything to zero immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            slot_q[i] <= '0;
         end
         sel_q      <= 2'd0;
         depth_q    <= 3'd0;
         valid_q    <= 1'b0;
         undo_err_q <= 1'b0;
         moves_q    <= '0;
      end else begin
         if (wr_en) begin
            slot_q[wr_idx] <= wr_data;
         end
         sel_q      <= sel_d;
         depth_q    <= depth_d;
         valid_q    <= (depth_d != 3'd0);
         undo_err_q <= undo_err_d;
         moves_q    <= moves_d;
      end
   end

   assign slot_0   = slot_q[0];
   assign slot_1   = slot_q[1];
   assign slot_2   = slot_q[2];
   assign slot_3   = slot_q[3];
   assign sel      = sel_q;
   assign depth    = depth_q;
   assign valid    = valid_q;
   assign undo_err = undo_err_q;
   assign moves    = moves_q;

`ifdef GAME_UNDO_STATS_EN
   logic        undo_acc;
   logic [15:0] undo_total_q;

   assign undo_acc = undo && !load && !push && (depth_q >= 3'd2);

   // Saturating count of accepted undos; a level load does not clear it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         undo_total_q <= 16'd0;
      end else if (undo_acc && (undo_total_q != 16'hFFFF)) begin
         undo_total_q <= undo_total_q + 16'd1;
      end
   end

   assign undo_total = undo_total_q;
`else
   assign undo_total = 16'd0;
`endif

endmodule

// File: tb/tb_game_undo_buffer.sv
// Directed bench for game_undo_buffer: a vector table of one-cycle commands and their expected
// registered outputs, plus a hand-written reset-mid-sequence check.
module tb_game_undo_buffer;

   localparam int unsigned N      = 134;
   localparam int unsigned MOVE_W = 16;

   localparam logic [N-1:0] Z  = '0;
   localparam logic [N-1:0] SA = {6'h2A, 64'h0, 64'h0000_0000_0000_000A};
   localparam logic [N-1:0] SB = {6'h15, 64'hBBBB_0000_0000_0000, 64'h0B};
   localparam logic [N-1:0] SC = {6'h01, 64'h0, 64'hCCCC_CCCC_CCCC_CCCC};
   localparam logic [N-1:0] SD = {6'h3F, 64'hDDDD_DDDD_DDDD_DDDD, 64'h0D};
   localparam logic [N-1:0] SE = {6'h20, 64'h0000_0000_0000_00EE, 64'hE000_0000_0000_0000};
   localparam logic [N-1:0] SX = {6'h11, 64'h1234_5678_9ABC_DEF0, 64'h77};
   localparam logic [N-1:0] SF = {6'h0F, 64'hF, 64'hF0F0};
   localparam logic [N-1:0] SG = {6'h30, 64'h6666, 64'h6};
   localparam logic [N-1:0] SP = {6'h05, 64'h5050, 64'h5};
   localparam logic [N-1:0] SQ = {6'h0C, 64'h0, 64'hC0C0_C0C0};

   logic              clk, rst_n, load, push, undo;
   logic [N-1:0]      load_state, push_state;
   logic [N-1:0]      slot_0, slot_1, slot_2, slot_3;
   logic [1:0]        sel;
   logic [2:0]        depth;
   logic              valid, undo_err;
   logic [MOVE_W-1:0] moves;
   logic [15:0]       undo_total;

   int checks   = 0;
   int failures = 0;

   game_undo_buffer #(.N(N), .MOVE_W(MOVE_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load),
      .load_state (load_state),
      .push       (push),
      .push_state (push_state),
      .undo       (undo),
      .slot_0     (slot_0),
      .slot_1     (slot_1),
      .slot_2     (slot_2),
      .slot_3     (slot_3),
      .sel        (sel),
      .depth      (depth),
      .valid      (valid),
      .undo_err   (undo_err),
      .moves      (moves),
      .undo_total (undo_total)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic         ld;
      logic [N-1:0] ls;
      logic         ph;
      logic [N-1:0] ps;
      logic         un;
      logic [1:0]   sel;
      logic [2:0]   dep;
      logic         err;
      logic [15:0]  mv;
      logic [N-1:0] s0, s1, s2, s3;
      logic [15:0]  ut;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic ld, input logic [N-1:0] ls, input logic ph,
                      input logic [N-1:0] ps, input logic un, input logic [1:0] s,
                      input logic [2:0] d, input logic e, input logic [15:0] m,
                      input logic [N-1:0] a0, input logic [N-1:0] a1,
                      input logic [N-1:0] a2, input logic [N-1:0] a3, input logic [15:0] u);
      vec_t v;
      v.ld = ld; v.ls = ls; v.ph = ph; v.ps = ps; v.un = un;
      v.sel = s; v.dep = d; v.err = e; v.mv = m;
      v.s0 = a0; v.s1 = a1; v.s2 = a2; v.s3 = a3; v.ut = u;
      vecs.push_back(v);
   endtask

   function automatic logic [15:0] exp_ut(input logic [15:0] u);
`ifdef GAME_UNDO_STATS_EN
      return u;
`else
      return 16'd0 & u;
`endif
   endfunction

   task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [1:0] s, input logic [2:0] d,
                          input logic e, input logic [15:0] m, input logic [N-1:0] a0,
                          input logic [N-1:0] a1, input logic [N-1:0] a2,
                          input logic [N-1:0] a3, input logic [15:0] u);
      chk({tag, ".sel"}, N'(sel), N'(s));
      chk({tag, ".depth"}, N'(depth), N'(d));
      chk({tag, ".valid"}, N'(valid), N'(d != 3'd0));
      chk({tag, ".undo_err"}, N'(undo_err), N'(e));
      chk({tag, ".moves"}, N'(moves), N'(m));
      chk({tag, ".slot_0"}, slot_0, a0);
      chk({tag, ".slot_1"}, slot_1, a1);
      chk({tag, ".slot_2"}, slot_2, a2);
      chk({tag, ".slot_3"}, slot_3, a3);
      chk({tag, ".undo_total"}, N'(undo_total), N'(exp_ut(u)));
   endtask

   initial begin
      rst_n = 1'b0; load = 1'b0; push = 1'b0; undo = 1'b0;
      load_state = '0; push_state = '0;

      // Test 1: load then rejected undo.
      add(1, SA, 0, Z,  0, 2'd0, 3'd1, 0, 16'd0, SA, Z,  Z,  Z,  16'd0);
      add(0, Z,  0, Z,  1, 2'd0, 3'd1, 1, 16'd0, SA, Z,  Z,  Z,  16'd0);
      add(0, Z,  0, Z,  0, 2'd0, 3'd1, 0, 16'd0, SA, Z,  Z,  Z,  16'd0);
      // Test 2: fill the ring, then wrap over the oldest state.
      add(1, SA, 0, Z,  0, 2'd0, 3'd1, 0, 16'd0, SA, Z,  Z,  Z,  16'd0);
      add(0, Z,  1, SB, 0, 2'd1, 3'd2, 0, 16'd1, SA, SB, Z,  Z,  16'd0);
      add(0, Z,  1, SC, 0, 2'd2, 3'd3, 0, 16'd2, SA, SB, SC, Z,  16'd0);
      add(0, Z,  1, SD, 0, 2'd3, 3'd4, 0, 16'd3, SA, SB, SC, SD, 16'd0);
      add(0, Z,  1, SE, 0, 2'd0, 3'd4, 0, 16'd4, SE, SB, SC, SD, 16'd0);
      // Test 3: three undos accepted, fourth rejected; load keeps undo_total.
      add(0, Z,  0, Z,  1, 2'd3, 3'd3, 0, 16'd3, SE, SB, SC, SD, 16'd1);
      add(0, Z,  0, Z,  1, 2'd2, 3'd2, 0, 16'd2, SE, SB, SC, SD, 16'd2);
      add(0, Z,  0, Z,  1, 2'd1, 3'd1, 0, 16'd1, SE, SB, SC, SD, 16'd3);
      add(0, Z,  0, Z,  1, 2'd1, 3'd1, 1, 16'd1, SE, SB, SC, SD, 16'd3);
      add(1, SA, 0, Z,  0, 2'd0, 3'd1, 0, 16'd0, SA, SB, SC, SD, 16'd3);
      // Test 4: push after undo discards the redo entry.
      add(0, Z,  1, SB, 0, 2'd1, 3'd2, 0, 16'd1, SA, SB, SC, SD, 16'd3);
      add(0, Z,  0, Z,  1, 2'd0, 3'd1, 0, 16'd0, SA, SB, SC, SD, 16'd4);
      add(0, Z,  1, SX, 0, 2'd1, 3'd2, 0, 16'd1, SA, SX, SC, SD, 16'd4);
      add(0, Z,  0, Z,  1, 2'd0, 3'd1, 0, 16'd0, SA, SX, SC, SD, 16'd5);
      add(0, Z,  0, Z,  1, 2'd0, 3'd1, 1, 16'd0, SA, SX, SC, SD, 16'd5);
      // Test 5: simultaneous strobes.
      add(1, SF, 1, SG, 1, 2'd0, 3'd1, 0, 16'd0, SF, SX, SC, SD, 16'd5);
      add(0, Z,  1, SG, 1, 2'd1, 3'd2, 1, 16'd1, SF, SG, SC, SD, 16'd5);
      add(0, Z,  0, Z,  0, 2'd1, 3'd2, 0, 16'd1, SF, SG, SC, SD, 16'd5);

      // Reset values, checked while reset is held.
      #12;
      chk_all("reset", 2'd0, 3'd0, 0, 16'd0, Z, Z, Z, Z, 16'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      foreach (vecs[i]) begin
         load = vecs[i].ld; load_state = vecs[i].ls;
         push = vecs[i].ph; push_state = vecs[i].ps;
         undo = vecs[i].un;
         @(posedge clk); #1;
         chk_all($sformatf("vec%0d", i), vecs[i].sel, vecs[i].dep, vecs[i].err, vecs[i].mv,
                 vecs[i].s0, vecs[i].s1, vecs[i].s2, vecs[i].s3, vecs[i].ut);
      end

      // Test 6: reset between edges during a push sequence.
      load = 1'b1; load_state = SA; push = 1'b0; undo = 1'b0;
      @(posedge clk); #1;
      load = 1'b0; push = 1'b1; push_state = SB;
      @(posedge clk); #1;
      chk_all("pre_rst", 2'd1, 3'd2, 0, 16'd1, SA, SB, SC, SD, 16'd5);
      push_state = SC;
      #3 rst_n = 1'b0;
      #1;
      chk_all("mid_rst", 2'd0, 3'd0, 0, 16'd0, Z, Z, Z, Z, 16'd0);
      @(posedge clk); #1;
      chk_all("rst_held", 2'd0, 3'd0, 0, 16'd0, Z, Z, Z, Z, 16'd0);
      // Push into an empty ring: written at sel, not counted as a move.
      rst_n = 1'b1; push_state = SP;
      @(posedge clk); #1;
      chk_all("push_empty", 2'd0, 3'd1, 0, 16'd0, SP, Z, Z, Z, 16'd0);
      push_state = SQ;
      @(posedge clk); #1;
      chk_all("push_second", 2'd1, 3'd2, 0, 16'd1, SP, SQ, Z, Z, 16'd0);
      push = 1'b0; undo = 1'b1;
      @(posedge clk); #1;
      chk_all("undo_after_rst", 2'd0, 3'd1, 0, 16'd0, SP, SQ, Z, Z, 16'd1);
      undo = 1'b0;
      @(posedge clk); #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
